// File: rtl/matcher_lookup_arbiter_pkg.sv
// Shared definitions for the matcher lookup arbiter: default widths,
// FSM state encoding, statistics counter width and small helpers.
package matcher_lookup_arbiter_pkg;

    localparam int OF_HEADER_REG_WIDTH  = 32;
    localparam int OF_ACTION_DATA_WIDTH = 16;
    localparam int OF_ACTION_CTRL_WIDTH = 8;

    localparam int CNT_WIDTH       = 16;
    localparam int DEFAULT_TIMEOUT = 64;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;

    // Single-step modulo wrap: valid while v < 2*n.
    function automatic int unsigned rr_wrap(input int unsigned v, input int unsigned n);
        return (v >= n) ? (v - n) : v;
    endfunction

    // Saturating add used by the drop and timeout statistics.
    function automatic logic [CNT_WIDTH-1:0] sat_add(input logic [CNT_WIDTH-1:0] cnt,
                                                     input logic [CNT_WIDTH-1:0] inc);
        logic [CNT_WIDTH:0] sum;
        sum = {1'b0, cnt} + {1'b0, inc};
        return sum[CNT_WIDTH] ? '1 : sum[CNT_WIDTH-1:0];
    endfunction

endpackage

// File: rtl/matcher_lookup_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: picks the first asserted request at or
// after the pointer, wrapping, and reports it as one-hot grant and index.
module rr_arbiter
    import matcher_lookup_arbiter_pkg::*;
#(
    parameter int N     = 2,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     i_req,
    input  logic [IDX_W-1:0] i_ptr,
    output logic [N-1:0]     o_grant,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_valid
);

    logic [IDX_W-1:0] w_cand;

    // Scan requests starting at the pointer; the first hit wins.
    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_valid = 1'b0;
        w_cand  = '0;
        for (int unsigned off = 0; off < N; off++) begin
            w_cand = IDX_W'(rr_wrap(32'(i_ptr) + off, N));
            if (!o_valid && i_req[w_cand]) begin
                o_valid         = 1'b1;
                o_grant[w_cand] = 1'b1;
                o_idx           = w_cand;
            end
        end
    end

endmodule

// File: rtl/matcher_lookup_arbiter.sv
// Shares one matcher lookup port between NUM_REQ header parsers. Each
// requester owns one header slot; slots are granted round-robin, one lookup
// is outstanding at a time, and each lookup is bounded by a timeout.
module matcher_lookup_arbiter
    import matcher_lookup_arbiter_pkg::*;
#(
    parameter int NUM_REQ   = 2,
    parameter int HDR_WIDTH = OF_HEADER_REG_WIDTH,
    parameter int RES_WIDTH = OF_ACTION_DATA_WIDTH + OF_ACTION_CTRL_WIDTH,
    parameter int TIMEOUT   = DEFAULT_TIMEOUT
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_REQ*HDR_WIDTH-1:0] req_hdr,
    input  logic [NUM_REQ-1:0]           req_valid,
    output logic [NUM_REQ-1:0]           req_busy,
    output logic [NUM_REQ-1:0]           resp_valid,
    output logic                         resp_hit,
    output logic                         resp_timeout,
    output logic [RES_WIDTH-1:0]         resp_data,
    output logic                         lkup_req,
    output logic [HDR_WIDTH-1:0]         lkup_hdr,
    input  logic                         lkup_ack,
    input  logic                         lkup_hit,
    input  logic [RES_WIDTH-1:0]         lkup_data,
    output logic [CNT_WIDTH-1:0]         drop_cnt,
    output logic [CNT_WIDTH-1:0]         tmo_cnt
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int TMR_W = $clog2(TIMEOUT);

    logic [1:0]           r_state;
    logic [NUM_REQ-1:0]   r_busy;
    logic [HDR_WIDTH-1:0] r_hdr [NUM_REQ];
    logic [IDX_W-1:0]     r_ptr;
    logic [NUM_REQ-1:0]   r_grant_oh;
    logic [TMR_W-1:0]     r_timer;
    logic                 r_hit;
    logic                 r_tmo;
    logic [RES_WIDTH-1:0] r_data;
    logic [HDR_WIDTH-1:0] r_lkup_hdr;
    logic [CNT_WIDTH-1:0] r_drop_cnt;
    logic [CNT_WIDTH-1:0] r_tmo_cnt;

    logic [NUM_REQ-1:0]   w_arb_grant;
    logic [IDX_W-1:0]     w_arb_idx;
    logic                 w_arb_valid;
    logic [NUM_REQ-1:0]   w_free;
    logic [NUM_REQ-1:0]   w_accept;
    logic [NUM_REQ-1:0]   w_drop;
    logic [CNT_WIDTH-1:0] w_drop_n;

    rr_arbiter #(
        .N     (NUM_REQ),
        .IDX_W (IDX_W)
    ) u_rr_arbiter (
        .i_req   (r_busy),
        .i_ptr   (r_ptr),
        .o_grant (w_arb_grant),
        .o_idx   (w_arb_idx),
        .o_valid (w_arb_valid)
    );

    // A slot is released in the RESP cycle; a new pulse in that cycle re-fills it.
    always_comb begin
        w_free   = (r_state == ST_RESP) ? r_grant_oh : '0;
        w_accept = req_valid & (~r_busy | w_free);
        w_drop   = req_valid & r_busy & ~w_free;
        w_drop_n = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            w_drop_n = w_drop_n + CNT_WIDTH'(w_drop[i]);
        end
    end

    // Slot occupancy and header capture per requester.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_busy <= '0;
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                r_hdr[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                if (w_accept[i]) begin
                    r_busy[i] <= 1'b1;
                    r_hdr[i]  <= req_hdr[i*HDR_WIDTH +: HDR_WIDTH];
                end else if (w_free[i]) begin
                    r_busy[i] <= 1'b0;
                end
            end
        end
    end

    // Saturating count of pulses that arrived while their slot was occupied.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_drop_cnt <= '0;
        end else if (|w_drop) begin
            r_drop_cnt <= sat_add(r_drop_cnt, w_drop_n);
        end
    end

    // Lookup sequencer: grant, strobe, wait for ack or timeout, respond.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_ptr      <= '0;
            r_grant_oh <= '0;
            r_timer    <= '0;
            r_hit      <= 1'b0;
            r_tmo      <= 1'b0;
            r_data     <= '0;
            r_lkup_hdr <= '0;
            r_tmo_cnt  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_arb_valid) begin
                        r_grant_oh <= w_arb_grant;
                        r_ptr      <= IDX_W'(rr_wrap(32'(w_arb_idx) + 32'd1, NUM_REQ));
                        r_lkup_hdr <= r_hdr[w_arb_idx];
                        r_state    <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    r_timer <= '0;
                    r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    // An ack arriving on the expiry cycle still counts as a result.
                    if (lkup_ack) begin
                        r_hit   <= lkup_hit;
                        r_data  <= lkup_hit ? lkup_data : '0;
                        r_tmo   <= 1'b0;
                        r_state <= ST_RESP;
                    end else if (r_timer == TMR_W'(TIMEOUT - 1)) begin
                        r_hit     <= 1'b0;
                        r_data    <= '0;
                        r_tmo     <= 1'b1;
                        r_tmo_cnt <= sat_add(r_tmo_cnt, CNT_WIDTH'(1));
                        r_state   <= ST_RESP;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                ST_RESP: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign req_busy     = r_busy;
    assign resp_valid   = w_free;
    assign resp_hit     = (r_state == ST_RESP) & r_hit;
    assign resp_timeout = (r_state == ST_RESP) & r_tmo;
    assign resp_data    = (r_state == ST_RESP) ? r_data : '0;
    assign lkup_req     = (r_state == ST_ISSUE);
    assign lkup_hdr     = r_lkup_hdr;
    assign drop_cnt     = r_drop_cnt;
    assign tmo_cnt      = r_tmo_cnt;

endmodule
